// File: rtl/srl_arbiter_pkg.sv
// srl_arb_pkg -- shared types and constants for the SR-latch arbiter.
//   arb_state_t : FSM state encoding
//   CMD_SET/CLR : per-requester command encoding (1 drives q high, 0 drives q low)
//   N_REQ_DEF / MAX_RETRY_DEF : default parameter values
//   ptr_width() : width of a requester index for a given requester count
package srl_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_CHECK = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    localparam logic CMD_SET = 1'b1;
    localparam logic CMD_CLR = 1'b0;

    localparam int N_REQ_DEF     = 4;
    localparam int MAX_RETRY_DEF = 2;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/srl_arbiter_if.sv
// srl_arbiter_if -- requester-side bundle of the SR-latch arbiter.
//   req  : per-requester request level          (requester -> arbiter)
//   cmd  : per-requester command, 1=SET 0=CLR   (requester -> arbiter)
//   lock : per-requester pointer lock, only when SRL_ARB_LOCK_EN is defined
//   gnt  : one-hot grant for the whole operation (arbiter -> requester)
//   done : one-cycle success pulse               (arbiter -> requester)
//   err  : one-cycle failure pulse               (arbiter -> requester)
//   busy : arbiter not idle                      (arbiter -> requester)
// Modports: master = requester side, slave = arbiter side.
interface srl_arbiter_if #(
    parameter int N_REQ = srl_arb_pkg::N_REQ_DEF
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] cmd;
    logic [N_REQ-1:0] gnt;
    logic [N_REQ-1:0] done;
    logic [N_REQ-1:0] err;
    logic             busy;
`ifdef SRL_ARB_LOCK_EN
    logic [N_REQ-1:0] lock;

    modport master (output req, cmd, lock, input gnt, done, err, busy);
    modport slave  (input req, cmd, lock, output gnt, done, err, busy);
`else
    modport master (output req, cmd, input gnt, done, err, busy);
    modport slave  (input req, cmd, output gnt, done, err, busy);
`endif
endinterface

// File: rtl/srl_arbiter_rr_pick.sv
// srl_rr_pick -- combinational round-robin selector.
//   req      : request vector
//   ptr      : index with highest priority this round
//   grant_oh : one-hot winner (first set bit at or above ptr, cyclic)
//   valid    : at least one request present
module srl_rr_pick
    import srl_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    localparam int PW   = ptr_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] grant_oh,
    output logic             valid
);

    // One extra bit so ptr + offset can exceed N_REQ before wrapping.
    logic [PW:0] pos;

    always_comb begin
        grant_oh = '0;
        valid    = 1'b0;
        pos      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pos = {1'b0, ptr} + (PW+1)'(i);
            if (pos >= (PW+1)'(N_REQ)) begin
                pos = pos - (PW+1)'(N_REQ);
            end
            if (!valid && req[pos[PW-1:0]]) begin
                grant_oh[pos[PW-1:0]] = 1'b1;
                valid                 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/srl_arbiter.sv
// srl_arbiter -- round-robin arbiter that sets/clears an external SR latch on
// behalf of N_REQ requesters and verifies the result by reading the latch back.
//   clk, reset : clock, synchronous active-high reset
//   bus        : srl_arbiter_if.slave (req, cmd, [lock], gnt, done, err, busy)
//   srl_s/srl_r: latch drive, only non-zero during ISSUE, never both high
//   srl_q/srl_q_bar : latch readback
// Optional feature: define SRL_ARB_LOCK_EN to add bus.lock; a requester with
// its lock bit high at the end of its operation keeps the round-robin pointer.
// The interface instance must be built with the same N_REQ as this module.
//
// state  | meaning
// IDLE   | no operation; arbitrate among requests
// ISSUE  | drive latch for one cycle (SET: s=0,r=1 / CLR: s=1,r=0)
// CHECK  | compare readback with target; retry or finish
// RESP   | pulse done or err to the winner, advance pointer
module srl_arbiter
    import srl_arb_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int MAX_RETRY = MAX_RETRY_DEF
) (
    input  logic          clk,
    input  logic          reset,
    srl_arbiter_if.slave  bus,
    output logic          srl_s,
    output logic          srl_r,
    input  logic          srl_q,
    input  logic          srl_q_bar
);

    localparam int PW = ptr_width(N_REQ);

    arb_state_t       state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    winner;
    logic             tgt;
    logic [2:0]       retry_cnt;
    logic [N_REQ-1:0] gnt_q;
    logic [N_REQ-1:0] done_q;
    logic [N_REQ-1:0] err_q;
    logic             busy_q;

    logic [N_REQ-1:0] pick_oh;
    logic             pick_valid;
    logic [PW-1:0]    pick_idx;
    logic [PW-1:0]    next_ptr;
    logic             pass;

    srl_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req      (bus.req),
        .ptr      (ptr),
        .grant_oh (pick_oh),
        .valid    (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_oh[i]) begin
                pick_idx = PW'(i);
            end
        end
    end

    assign next_ptr = (winner == PW'(N_REQ-1)) ? '0 : winner + 1'b1;

    // A healthy latch shows the target on q and its complement on q_bar.
    assign pass = (srl_q == tgt) && (srl_q_bar == ~srl_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            winner    <= '0;
            tgt       <= CMD_CLR;
            retry_cnt <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            err_q     <= '0;
            busy_q    <= 1'b0;
            srl_s     <= 1'b0;
            srl_r     <= 1'b0;
        end else begin
            done_q <= '0;
            err_q  <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        winner <= pick_idx;
                        tgt    <= bus.cmd[pick_idx];
                        gnt_q  <= pick_oh;
                        busy_q <= 1'b1;
                        srl_s  <= (bus.cmd[pick_idx] == CMD_CLR);
                        srl_r  <= (bus.cmd[pick_idx] == CMD_SET);
                        state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    srl_s <= 1'b0;
                    srl_r <= 1'b0;
                    state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (pass) begin
                        done_q <= gnt_q;
                        state  <= ST_RESP;
                    end else if (retry_cnt < 3'(MAX_RETRY)) begin
                        retry_cnt <= retry_cnt + 1'b1;
                        srl_s     <= (tgt == CMD_CLR);
                        srl_r     <= (tgt == CMD_SET);
                        state     <= ST_ISSUE;
                    end else begin
                        err_q <= gnt_q;
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    gnt_q     <= '0;
                    busy_q    <= 1'b0;
                    retry_cnt <= '0;
`ifdef SRL_ARB_LOCK_EN
                    ptr <= bus.lock[winner] ? winner : next_ptr;
`else
                    ptr <= next_ptr;
`endif
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_srl_arbiter.sv
module tb_srl_arbiter;
    import srl_arb_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic reset;
    logic srl_s, srl_r;
    logic srl_q = 1'b0;
    logic srl_q_bar;
    logic stuck;

    always #5 clk = ~clk;

    srl_arbiter_if #(.N_REQ(N)) bus();

    srl_arbiter #(.N_REQ(N), .MAX_RETRY(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .srl_s     (srl_s),
        .srl_r     (srl_r),
        .srl_q     (srl_q),
        .srl_q_bar (srl_q_bar)
    );

    // Latch model: r pulse sets q, s pulse clears q; stuck holds q at 0.
    always @(posedge clk) begin
        if (stuck)      srl_q <= 1'b0;
        else if (srl_r) srl_q <= 1'b1;
        else if (srl_s) srl_q <= 1'b0;
    end
    assign srl_q_bar = ~srl_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int idx;
        bit ok;
        int at;
    } exp_t;

    exp_t sb[$];
    int n_pass  = 0;
    int n_total = 0;

    // Scoreboard consumer and per-cycle invariants.
    always @(negedge clk) begin
        exp_t e;
        logic [N-1:0] oh, exp_done, exp_err;
        if (!reset) begin
            n_total++;
            if ($onehot0(bus.gnt) !== 1'b1)
                $display("FAIL inv_gnt_onehot gnt=%b at cyc %0d", bus.gnt, cyc);
            else n_pass++;
            n_total++;
            if ((srl_s & srl_r) !== 1'b0)
                $display("FAIL inv_s_r s=%b r=%b at cyc %0d", srl_s, srl_r, cyc);
            else n_pass++;
            n_total++;
            if ((bus.done & bus.err) !== '0)
                $display("FAIL inv_done_err done=%b err=%b at cyc %0d", bus.done, bus.err, cyc);
            else n_pass++;
            if ((bus.done | bus.err) != '0) begin
                n_total++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_resp done=%b err=%b at cyc %0d, none expected",
                             bus.done, bus.err, cyc);
                end else begin
                    e  = sb.pop_front();
                    oh = '0;
                    oh[e.idx] = 1'b1;
                    exp_done = e.ok ? oh : '0;
                    exp_err  = e.ok ? '0 : oh;
                    if (bus.done !== exp_done || bus.err !== exp_err || cyc !== e.at)
                        $display("FAIL resp done=%b err=%b cyc=%0d, expected done=%b err=%b cyc=%0d",
                                 bus.done, bus.err, cyc, exp_done, exp_err, e.at);
                    else n_pass++;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        bus.req  = '0;
        bus.cmd  = '0;
`ifdef SRL_ARB_LOCK_EN
        bus.lock = '0;
`endif
        stuck    = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic check_drained(input string name);
        n_total++;
        if (sb.size() !== 0)
            $display("FAIL %s_drained pending=%0d expected 0", name, sb.size());
        else n_pass++;
        sb.delete();
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        bus.req = 4'b1111;
        bus.cmd = 4'b1111;
        stuck   = 1'b0;
        tick(2);
        n_total++;
        if ({bus.gnt, bus.done, bus.err, srl_s, srl_r, bus.busy} !== '0)
            $display("FAIL reset_outputs gnt=%b done=%b err=%b s=%b r=%b busy=%b expected all 0",
                     bus.gnt, bus.done, bus.err, srl_s, srl_r, bus.busy);
        else n_pass++;
        reset   = 1'b0;
        bus.req = '0;
        tick(2);
    endtask

    task automatic test_single();
        int c;
        do_reset();
        bus.cmd = 4'b0001;
        bus.req = 4'b0001;
        c = cyc;
        sb.push_back('{0, 1'b1, c + 3});
        tick(1);
        n_total++;
        if ({srl_s, srl_r, bus.gnt, bus.busy} !== {1'b0, 1'b1, 4'b0001, 1'b1})
            $display("FAIL single_issue s=%b r=%b gnt=%b busy=%b expected s=0 r=1 gnt=0001 busy=1",
                     srl_s, srl_r, bus.gnt, bus.busy);
        else n_pass++;
        bus.req = '0;
        tick(1);
        n_total++;
        if ({srl_s, srl_r, bus.gnt} !== {1'b0, 1'b0, 4'b0001})
            $display("FAIL single_check s=%b r=%b gnt=%b expected s=0 r=0 gnt=0001", srl_s, srl_r, bus.gnt);
        else n_pass++;
        tick(1);
        n_total++;
        if (srl_q !== 1'b1)
            $display("FAIL single_q q=%b expected 1", srl_q);
        else n_pass++;
        tick(1);
        n_total++;
        if ({bus.gnt, bus.busy} !== 5'b0)
            $display("FAIL single_idle gnt=%b busy=%b expected 0", bus.gnt, bus.busy);
        else n_pass++;
        tick(2);
        check_drained("single");
    endtask

    task automatic test_contention();
        int c;
        logic [N-1:0] oh;
        do_reset();
        bus.cmd = 4'b1111;
        bus.req = 4'b1111;
        c = cyc;
        for (int i = 0; i < 5; i++) sb.push_back('{i % N, 1'b1, c + 3 + 4*i});
        for (int i = 0; i < 5; i++) begin
            tick_to(c + 1 + 4*i);
            oh = '0;
            oh[i % N] = 1'b1;
            n_total++;
            if (bus.gnt !== oh)
                $display("FAIL contention_gnt%0d gnt=%b expected %b", i, bus.gnt, oh);
            else n_pass++;
        end
        tick_to(c + 19);
        bus.req = '0;
        tick(4);
        check_drained("contention");
    endtask

    task automatic test_stuck();
        int c, n_issue;
        do_reset();
        stuck   = 1'b1;
        bus.cmd = 4'b0001;
        bus.req = 4'b0001;
        c = cyc;
        sb.push_back('{0, 1'b0, c + 7});
        n_issue = 0;
        tick(1);
        bus.req = '0;
        for (int k = 0; k < 8; k++) begin
            if (srl_r === 1'b1) n_issue++;
            tick(1);
        end
        n_total++;
        if (n_issue !== 3)
            $display("FAIL stuck_issue_count issues=%0d expected 3", n_issue);
        else n_pass++;
        stuck = 1'b0;
        check_drained("stuck");
    endtask

    task automatic test_back_to_back();
        int c, c2;
        do_reset();
        bus.cmd = 4'b1000;
        bus.req = 4'b1000;
        c = cyc;
        sb.push_back('{3, 1'b1, c + 3});
        tick(1);
        bus.req = '0;
        tick_to(c + 4);
        // Second op starts in the first IDLE cycle after RESP; cmd and req
        // change right after ISSUE and must not disturb it.
        bus.cmd = 4'b0000;
        bus.req = 4'b0100;
        c2 = cyc;
        sb.push_back('{2, 1'b1, c2 + 3});
        tick(1);
        n_total++;
        if ({srl_s, srl_r, bus.gnt} !== {1'b1, 1'b0, 4'b0100})
            $display("FAIL b2b_issue s=%b r=%b gnt=%b expected s=1 r=0 gnt=0100", srl_s, srl_r, bus.gnt);
        else n_pass++;
        bus.cmd = 4'b1111;
        bus.req = '0;
        tick(2);
        n_total++;
        if (srl_q !== 1'b0)
            $display("FAIL b2b_q q=%b expected 0", srl_q);
        else n_pass++;
        tick(3);
        check_drained("b2b");
    endtask

    task automatic test_reset_midop();
        int c, c2, c3;
        do_reset();
        bus.cmd = 4'b0010;
        bus.req = 4'b0010;
        c = cyc;
        sb.push_back('{1, 1'b1, c + 3});
        tick(1);
        bus.req = '0;
        tick_to(c + 4);
        bus.cmd = 4'b0001;
        bus.req = 4'b0001;
        c2 = cyc;
        tick(2);
        n_total++;
        if (bus.gnt !== 4'b0001)
            $display("FAIL midop_pre gnt=%b expected 0001", bus.gnt);
        else n_pass++;
        reset = 1'b1;
        tick(1);
        n_total++;
        if ({bus.gnt, bus.done, bus.err, srl_s, srl_r, bus.busy} !== '0)
            $display("FAIL midop_reset gnt=%b done=%b err=%b s=%b r=%b busy=%b expected all 0",
                     bus.gnt, bus.done, bus.err, srl_s, srl_r, bus.busy);
        else n_pass++;
        reset   = 1'b0;
        bus.req = 4'b1111;
        c3 = cyc;
        sb.push_back('{0, 1'b1, c3 + 3});
        tick(1);
        n_total++;
        if (bus.gnt !== 4'b0001)
            $display("FAIL midop_ptr gnt=%b expected 0001", bus.gnt);
        else n_pass++;
        bus.req = '0;
        tick(5);
        check_drained("midop");
    endtask

`ifdef SRL_ARB_LOCK_EN
    task automatic test_lock();
        int c;
        do_reset();
        bus.cmd  = 4'b0011;
        bus.req  = 4'b0011;
        bus.lock = 4'b0001;
        c = cyc;
        sb.push_back('{0, 1'b1, c + 3});
        sb.push_back('{0, 1'b1, c + 7});
        sb.push_back('{0, 1'b1, c + 11});
        sb.push_back('{1, 1'b1, c + 15});
        tick_to(c + 9);
        n_total++;
        if (bus.gnt !== 4'b0001)
            $display("FAIL lock_hold gnt=%b expected 0001", bus.gnt);
        else n_pass++;
        tick_to(c + 11);
        bus.lock = '0;
        tick_to(c + 13);
        n_total++;
        if (bus.gnt !== 4'b0010)
            $display("FAIL lock_release gnt=%b expected 0010", bus.gnt);
        else n_pass++;
        tick_to(c + 15);
        bus.req = '0;
        tick(4);
        check_drained("lock");
    endtask
`endif

    initial begin
        reset    = 1'b1;
        stuck    = 1'b0;
        bus.req  = '0;
        bus.cmd  = '0;
`ifdef SRL_ARB_LOCK_EN
        bus.lock = '0;
`endif
        test_reset();
        test_single();
        test_contention();
        test_stuck();
        test_back_to_back();
        test_reset_midop();
`ifdef SRL_ARB_LOCK_EN
        test_lock();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
